// File: rtl/ps2_rx_fifo_if.sv
// PS/2 receive front end bus: raw pin inputs, FWFT read port and error pulses.
// Latency: n/a (signal bundle only).
// Backpressure: none; the reader pops with rd_en, the FIFO drops and flags overflow when full.
//   master: drives raw PS/2 pins and rd_en, observes FIFO head, occupancy and pulses
//   slave : the receiver, consumes pins and rd_en, presents FIFO state and pulses
interface ps2_rx_fifo_if #(
  parameter int FIFO_AW = 4
);
  logic               ps2_clk_in;
  logic               ps2_dat_in;
  logic               rd_en;
  logic [7:0]         rd_data;
  logic               empty;
  logic [FIFO_AW:0]   fifo_count;
  logic               parity_err;
  logic               frame_err;
  logic               overflow;

  modport master (
    output ps2_clk_in, ps2_dat_in, rd_en,
    input  rd_data, empty, fifo_count, parity_err, frame_err, overflow
  );

  modport slave (
    input  ps2_clk_in, ps2_dat_in, rd_en,
    output rd_data, empty, fifo_count, parity_err, frame_err, overflow
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sync + de-glitch pins, deframe 11-bit frames, queue good bytes in a FWFT FIFO.
// Latency: push/error pulse one cycle after the filtered stop-bit fall; FIFO head visible the cycle after push.
// Backpressure: none upstream; a good byte arriving with the FIFO full (and no pop) is dropped with an overflow pulse.
//   CLK_50MHZ : system clock, rising edge
//   RESET     : asynchronous active-high reset
//   bus       : slave side of ps2_rx_fifo_if (pins, rd_en in; rd_data/empty/fifo_count/pulses out)
module ps2_rx_fifo #(
  parameter int FIFO_AW        = 4,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic          CLK_50MHZ,
  input  logic          RESET,
  ps2_rx_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int FW    = $clog2(FILTER_LEN + 1);
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------- input synchroniser and filter (index 0 = clk, 1 = dat)
  logic [1:0]    w_pin;
  logic [1:0]    r_s1;
  logic [1:0]    r_s2;
  logic [1:0]    r_filt;
  logic          r_clk_d;
  logic [FW-1:0] r_fcnt [2];
  logic          w_fall;
  logic          w_dat;

  assign w_pin = {bus.ps2_dat_in, bus.ps2_clk_in};

  // The filtered value only moves after FILTER_LEN consecutive samples that
  // disagree with it; any agreeing sample restarts the run.
  always_ff @(posedge CLK_50MHZ or posedge RESET) begin
    if (RESET) begin
      r_s1    <= 2'b11;
      r_s2    <= 2'b11;
      r_filt  <= 2'b11;
      r_clk_d <= 1'b1;
      for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
    end else begin
      r_s1    <= w_pin;
      r_s2    <= r_s1;
      r_clk_d <= r_filt[0];
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FW'(FILTER_LEN - 1)) begin
          r_filt[i] <= r_s2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_fall = r_clk_d & ~r_filt[0];
  assign w_dat  = r_filt[1];

  // ---------------- frame FSM
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_to_cnt;
  logic          r_push;
  logic [7:0]    r_push_dat;
  logic          r_parity_err;
  logic          r_frame_err;

  always_ff @(posedge CLK_50MHZ or posedge RESET) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_to_cnt     <= '0;
      r_push       <= 1'b0;
      r_push_dat   <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_push       <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            if (!w_dat) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end else begin
              r_frame_err <= 1'b1;  // start bit must be 0
            end
          end
          S_DATA: begin
            r_shift   <= {w_dat, r_shift[7:1]};  // LSB arrives first
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_par   <= w_dat;
            r_state <= S_STOP;
          end
          S_STOP: begin
            // Bad stop outranks bad parity so each frame yields at most one pulse.
            if (!w_dat) begin
              r_frame_err <= 1'b1;
            end else if ((^r_shift ^ r_par) == 1'b0) begin
              r_parity_err <= 1'b1;
            end else begin
              r_push     <= 1'b1;
              r_push_dat <= r_shift;
            end
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state == S_IDLE) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        // Device stalled mid-frame: abandon it.
        r_state     <= S_IDLE;
        r_frame_err <= 1'b1;
        r_to_cnt    <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  // ---------------- FWFT FIFO
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               w_empty;
  logic               w_full;
  logic               w_rd;
  logic               w_wr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (FIFO_AW + 1)'(DEPTH));
  assign w_rd    = bus.rd_en & ~w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_wr    = r_push & (~w_full | w_rd);

  always_ff @(posedge CLK_50MHZ) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_push_dat;
  end

  always_ff @(posedge CLK_50MHZ or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.rd_data    = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign bus.empty      = w_empty;
  assign bus.fifo_count = r_count;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;
  assign bus.overflow   = r_push & w_full & ~w_rd;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed PS/2 frames, expected events queued by stimulus, checked by a monitor.
// Latency: shortened bit period and timeout keep the run to a few tens of thousands of cycles.
// Backpressure: reader pops are issued explicitly by the stimulus.
module tb_ps2_rx_fifo;
  localparam int AW = 4;
  localparam int FL = 8;
  localparam int TO = 1000;
  localparam int HB = 20;  // half PS/2 bit period in system clocks

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_rx_fifo_if #(.FIFO_AW(AW)) bus();

  ps2_rx_fifo #(.FIFO_AW(AW), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) u_dut (
    .CLK_50MHZ (clk),
    .RESET     (rst),
    .bus       (bus)
  );

  typedef enum int {EV_BYTE, EV_PERR, EV_FERR, EV_OVF} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] dat;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_miss = 0;
  int  cyc = 0;
  int  ferr_cyc = -1;
  int  last_fall_cyc = 0;
  logic prev_perr = 1'b0, prev_ferr = 1'b0, prev_ovf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.dat  = d;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL unexpected_event: got %s %02h, expected nothing", k.name(), d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.dat != d) begin
        n_miss++;
        $display("FAIL event: got %s %02h, expected %s %02h", k.name(), d, e.kind.name(), e.dat);
      end
    end
  endtask

  // Monitor: every DUT-presented event is matched against the expectation queue.
  always @(negedge clk) begin
    if (rst) begin
      prev_perr = 1'b0;
      prev_ferr = 1'b0;
      prev_ovf  = 1'b0;
    end else begin
      if (prev_perr) chk("parity_err_width", int'(bus.parity_err), 0);
      if (prev_ferr) chk("frame_err_width", int'(bus.frame_err), 0);
      if (prev_ovf)  chk("overflow_width", int'(bus.overflow), 0);
      if (bus.parity_err) got_ev(EV_PERR, 8'h00);
      if (bus.frame_err) begin
        got_ev(EV_FERR, 8'h00);
        ferr_cyc = cyc;
      end
      if (bus.overflow) got_ev(EV_OVF, 8'h00);
      if (bus.rd_en && !bus.empty) got_ev(EV_BYTE, bus.rd_data);
      prev_perr = bus.parity_err;
      prev_ferr = bus.frame_err;
      prev_ovf  = bus.overflow;
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bit: data set while clock high, then a low phase. Optional 3-cycle
  // clock glitch in the high phase, or a single pop aligned with the cycle
  // in which the receiver pushes after this (stop) bit's falling edge:
  // 2 sync stages + FILTER_LEN filter samples + registered edge + registered push.
  task automatic put_bit(input logic b, input bit glitch, input bit pop_stop);
    bus.ps2_dat_in = b;
    if (glitch) begin
      cyc_wait(5);
      bus.ps2_clk_in = 1'b0;
      cyc_wait(3);
      bus.ps2_clk_in = 1'b1;
      cyc_wait(HB - 8);
    end else begin
      cyc_wait(HB);
    end
    bus.ps2_clk_in = 1'b0;
    last_fall_cyc  = cyc;
    if (pop_stop) begin
      cyc_wait(FL + 3);
      bus.rd_en = 1'b1;
      cyc_wait(1);
      bus.rd_en = 1'b0;
      cyc_wait(HB - FL - 4);
    end else begin
      cyc_wait(HB);
    end
    bus.ps2_clk_in = 1'b1;
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input bit bad_par, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (i == 9) return (~^d) ^ bad_par;
    return 1'b1;
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input int glitch_bit, input bit pop_stop);
    for (int i = 0; i < 11; i++)
      put_bit(frame_bit(d, bad_par, i), glitch_bit == i, pop_stop && i == 10);
    bus.ps2_dat_in = 1'b1;
    cyc_wait(3 * HB);
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    for (int i = 0; i < nbits; i++) put_bit(frame_bit(d, 1'b0, i), 1'b0, 1'b0);
    bus.ps2_dat_in = 1'b1;
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    cyc_wait(1);
    bus.rd_en = 1'b0;
    cyc_wait(1);
  endtask

  initial begin
    int fall_at;
    int diff;
    bus.ps2_clk_in = 1'b1;
    bus.ps2_dat_in = 1'b1;
    bus.rd_en      = 1'b0;
    rst            = 1'b1;
    cyc_wait(5);
    chk("reset_empty", int'(bus.empty), 1);
    chk("reset_count", int'(bus.fifo_count), 0);
    chk("reset_rd_data", int'(bus.rd_data), 0);
    chk("reset_pulses", int'({bus.parity_err, bus.frame_err, bus.overflow}), 0);
    rst = 1'b0;
    cyc_wait(20);

    // 1: single good frame 0x1C
    send_frame(8'h1C, 1'b0, -1, 1'b0);
    chk("t1_empty", int'(bus.empty), 0);
    chk("t1_count", int'(bus.fifo_count), 1);
    chk("t1_head", int'(bus.rd_data), 8'h1C);
    expect_ev(EV_BYTE, 8'h1C);
    pop();
    chk("t1_empty_after_pop", int'(bus.empty), 1);

    // 2: bad parity
    expect_ev(EV_PERR, 8'h00);
    send_frame(8'h1C, 1'b1, -1, 1'b0);
    chk("t2_count", int'(bus.fifo_count), 0);

    // 3: 17 frames into a 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      if (i == 16) expect_ev(EV_OVF, 8'h00);
      send_frame(8'(i), 1'b0, -1, 1'b0);
    end
    chk("t3_count_full", int'(bus.fifo_count), 16);
    for (int i = 0; i < 16; i++) begin
      expect_ev(EV_BYTE, 8'(i));
      pop();
    end
    chk("t3_empty", int'(bus.empty), 1);
    pop();  // pop on empty: no event, count stays 0
    chk("t3_pop_empty_count", int'(bus.fifo_count), 0);

    // 4: clock glitches idle and mid-frame
    bus.ps2_clk_in = 1'b0;
    cyc_wait(3);
    bus.ps2_clk_in = 1'b1;
    cyc_wait(30);
    send_frame(8'hAA, 1'b0, 4, 1'b0);
    chk("t4_count", int'(bus.fifo_count), 1);
    expect_ev(EV_BYTE, 8'hAA);
    pop();

    // 5: stall after 4 data bits
    send_partial(8'h0F, 5);
    fall_at  = last_fall_cyc;
    ferr_cyc = -1;
    expect_ev(EV_FERR, 8'h00);
    cyc_wait(TO + 200);
    diff = ferr_cyc - fall_at;
    n_vec++;
    if (ferr_cyc < 0 || diff < TO || diff > TO + 40) begin
      n_miss++;
      $display("FAIL t5_timeout_delay: got %0d cycles, expected %0d..%0d", diff, TO, TO + 40);
    end
    send_frame(8'hF0, 1'b0, -1, 1'b0);
    expect_ev(EV_BYTE, 8'hF0);
    pop();

    // 6: reset mid-frame with bytes queued
    send_frame(8'h11, 1'b0, -1, 1'b0);
    send_frame(8'h22, 1'b0, -1, 1'b0);
    send_frame(8'h33, 1'b0, -1, 1'b0);
    chk("t6_count3", int'(bus.fifo_count), 3);
    send_partial(8'h44, 4);
    rst = 1'b1;
    cyc_wait(3);
    chk("t6_rst_empty", int'(bus.empty), 1);
    chk("t6_rst_count", int'(bus.fifo_count), 0);
    rst = 1'b0;
    cyc_wait(20);
    send_frame(8'h5A, 1'b0, -1, 1'b0);
    chk("t6_count_5a", int'(bus.fifo_count), 1);
    expect_ev(EV_BYTE, 8'h5A);
    pop();
    for (int i = 0; i < 16; i++) send_frame(8'h80 + 8'(i), 1'b0, -1, 1'b0);
    chk("t6_full", int'(bus.fifo_count), 16);
    expect_ev(EV_BYTE, 8'h80);
    send_frame(8'h99, 1'b0, -1, 1'b1);
    chk("t6_full_after_push_pop", int'(bus.fifo_count), 16);
    for (int i = 1; i < 16; i++) begin
      expect_ev(EV_BYTE, 8'h80 + 8'(i));
      pop();
    end
    expect_ev(EV_BYTE, 8'h99);
    pop();
    chk("t6_empty_end", int'(bus.empty), 1);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) cyc_wait(1);
    chk("expect_queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #(80000 * 10);
    $display("FAIL watchdog: simulation exceeded %0d cycles", 80000);
    $fatal(1, "watchdog");
  end
endmodule
